// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared constants and state encoding for the data memory arbiter
package data_mem_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_MEM_SIZE   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-port round-robin pick, combinational one-hot grant
module rr_arbiter_2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    // ptr_i = 0 favours port 0 on a tie; a lone requester always wins
    always_comb begin
        gnt_o = 2'b00;
        if (req_i[0] && req_i[1]) begin
            gnt_o = ptr_i ? 2'b10 : 2'b01;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port arbiter sharing one data memory, fixed 2-cycle latency
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int DATA_MEM_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_MEM_WIDTH      = DEF_DATA_WIDTH,
    parameter int DATA_MEM_SIZE       = DEF_MEM_SIZE
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           p0_req,
    input  logic [DATA_MEM_ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_MEM_WIDTH-1:0]      p0_wdata,
    input  logic                           p0_write,
    output logic                           p0_ack,
    output logic [DATA_MEM_WIDTH-1:0]      p0_rdata,
    output logic                           p0_exc,
    input  logic                           p1_req,
    input  logic [DATA_MEM_ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_MEM_WIDTH-1:0]      p1_wdata,
    input  logic                           p1_write,
    output logic                           p1_ack,
    output logic [DATA_MEM_WIDTH-1:0]      p1_rdata,
    output logic                           p1_exc,
    output logic [DATA_MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_MEM_WIDTH-1:0]      mem_data_in,
    output logic                           mem_write,
    input  logic [DATA_MEM_WIDTH-1:0]      mem_data_out
);

    localparam logic [DATA_MEM_ADDR_WIDTH-1:0] SIZE_A = DATA_MEM_ADDR_WIDTH'(DATA_MEM_SIZE);

    state_e                           state_q, state_d;
    logic                             ptr_q, ptr_d;
    logic                             win_q, win_d;
    logic [DATA_MEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_MEM_WIDTH-1:0]        wdata_q, wdata_d;
    logic                             write_q, write_d;
    logic [DATA_MEM_WIDTH-1:0]        rdata_q, rdata_d;

    logic [1:0]                       gnt;
    logic                             take, take_p1;
    logic                             other_req;
    logic                             in_range;
    logic [DATA_MEM_WIDTH-1:0]        resp_rdata;

    rr_arbiter_2 u_rr (
        .req_i ({p1_req, p0_req}),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    assign in_range   = (addr_q < SIZE_A);
    assign other_req  = win_q ? p0_req : p1_req;
    assign resp_rdata = (!write_q && in_range) ? rdata_q : '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        rdata_d     = rdata_q;
        take        = 1'b0;
        take_p1     = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        mem_write   = 1'b0;
        p0_ack      = 1'b0;
        p1_ack      = 1'b0;
        p0_rdata    = '0;
        p1_rdata    = '0;
        p0_exc      = 1'b0;
        p1_exc      = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt[0] || gnt[1]) begin
                    take    = 1'b1;
                    take_p1 = gnt[1];
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr    = addr_q;
                mem_data_in = wdata_q;
                mem_write   = write_q && in_range;
                rdata_d     = mem_data_out;
                state_d     = RESP;
            end
            RESP: begin
                if (win_q) begin
                    p1_ack   = 1'b1;
                    p1_rdata = resp_rdata;
                    p1_exc   = !in_range;
                end else begin
                    p0_ack   = 1'b1;
                    p0_rdata = resp_rdata;
                    p0_exc   = !in_range;
                end
                ptr_d = ~win_q;
                // The acked port is ignored here; only the waiting port can chain in
                if (other_req) begin
                    take    = 1'b1;
                    take_p1 = ~win_q;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            win_d   = take_p1;
            addr_d  = take_p1 ? p1_addr  : p0_addr;
            wdata_d = take_p1 ? p1_wdata : p0_wdata;
            write_d = take_p1 ? p1_write : p0_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            win_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter with a 3-word memory model
module tb_data_mem_arbiter;

    localparam int SZ = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 1'b0, p1_req = 1'b0;
    logic [15:0] p0_addr = '0, p1_addr = '0;
    logic [15:0] p0_wdata = '0, p1_wdata = '0;
    logic        p0_write = 1'b0, p1_write = 1'b0;
    logic        p0_ack, p1_ack, p0_exc, p1_exc;
    logic [15:0] p0_rdata, p1_rdata;
    logic [15:0] mem_addr, mem_data_in, mem_data_out;
    logic        mem_write;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .DATA_MEM_ADDR_WIDTH(16),
        .DATA_MEM_WIDTH     (16),
        .DATA_MEM_SIZE      (SZ)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_write(p0_write),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_exc(p0_exc),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_write(p1_write),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_exc(p1_exc),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write(mem_write),
        .mem_data_out(mem_data_out)
    );

    // data memory model: word 0 comes out of reset as 16'h2bcd
    logic [15:0] mem [0:2];
    always_comb mem_data_out = (mem_addr < 16'(SZ)) ? mem[mem_addr[1:0]] : 16'h0;
    always @(posedge clk) begin
        if (rst) begin
            mem[0] <= 16'h2bcd;
            mem[1] <= 16'h0;
            mem[2] <= 16'h0;
        end else if (mem_write && mem_addr < 16'(SZ)) begin
            mem[mem_addr[1:0]] <= mem_data_in;
        end
    end

    typedef struct {
        int          port;
        logic [15:0] rdata;
        logic        exc;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] shadow [0:2];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          wr_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int   port;
        exp_t e;
        if (mem_write) wr_cnt = wr_cnt + 1;
        if (p0_ack || p1_ack) begin
            port = p1_ack ? 1 : 0;
            total++;
            if (p0_ack && p1_ack) begin
                bad++; $display("FAIL both_acks cyc=%0d got p0=1 p1=1 want one", cyc);
            end
            total++;
            if (sb.size() == 0) begin
                bad++; $display("FAIL unexpected_ack port=%0d cyc=%0d want no ack", port, cyc);
            end else begin
                e = sb.pop_front();
                if (port !== e.port) begin
                    bad++; $display("FAIL ack_port got=%0d want=%0d", port, e.port);
                end
                total++;
                if (cyc !== e.cyc) begin
                    bad++; $display("FAIL ack_cycle port=%0d got=%0d want=%0d", port, cyc, e.cyc);
                end
                total++;
                if ((port == 0 ? p0_rdata : p1_rdata) !== e.rdata) begin
                    bad++; $display("FAIL rdata port=%0d got=%h want=%h", port,
                                    (port == 0 ? p0_rdata : p1_rdata), e.rdata);
                end
                total++;
                if ((port == 0 ? p0_exc : p1_exc) !== e.exc) begin
                    bad++; $display("FAIL exc port=%0d got=%b want=%b", port,
                                    (port == 0 ? p0_exc : p1_exc), e.exc);
                end
                total++;
                if ((port == 0 ? {p1_rdata, p1_exc} : {p0_rdata, p0_exc}) !== 17'h0) begin
                    bad++; $display("FAIL loser_outputs port=%0d got=%h want=0", 1 - port,
                                    (port == 0 ? {p1_rdata, p1_exc} : {p0_rdata, p0_exc}));
                end
                total++;
                if ({mem_write, mem_addr, mem_data_in} !== 33'h0) begin
                    bad++; $display("FAIL mem_idle_in_resp got we=%b a=%h d=%h want 0",
                                    mem_write, mem_addr, mem_data_in);
                end
            end
        end
    end

    task automatic init_shadow();
        shadow[0] = 16'h2bcd;
        shadow[1] = 16'h0;
        shadow[2] = 16'h0;
    endtask

    task automatic drive(input int port, input logic v, input logic [15:0] a,
                         input logic [15:0] wd, input logic wr);
        if (port == 0) begin
            p0_req = v; p0_addr = a; p0_wdata = wd; p0_write = wr;
        end else begin
            p1_req = v; p1_addr = a; p1_wdata = wd; p1_write = wr;
        end
    endtask

    task automatic push_exp(input int port, input logic [15:0] a, input logic [15:0] wd,
                            input logic wr, input int at);
        exp_t e;
        e.port  = port;
        e.exc   = (a >= 16'(SZ));
        e.rdata = (!wr && !e.exc) ? shadow[a[1:0]] : 16'h0;
        if (wr && !e.exc) shadow[a[1:0]] = wd;
        e.cyc   = at;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int port);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(port == 0 ? p0_ack : p1_ack) && n < 20);
        total++;
        if (!(port == 0 ? p0_ack : p1_ack)) begin
            bad++; $display("FAIL ack_timeout port=%0d got no ack want ack within 20", port);
        end
    endtask

    task automatic issue(input int port, input logic [15:0] a, input logic [15:0] wd,
                         input logic wr);
        push_exp(port, a, wd, wr, cyc + 2);
        drive(port, 1'b1, a, wd, wr);
        wait_ack(port);
        drive(port, 1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        init_shadow();
    endtask

    task automatic test_reset();
        drive(0, 1'b1, 16'h1, 16'h0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if ({p0_ack, p1_ack, p0_exc, p1_exc, mem_write} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=00000",
                            {p0_ack, p1_ack, p0_exc, p1_exc, mem_write});
        end
        total++;
        if ({p0_rdata, p1_rdata} !== 32'h0) begin
            bad++; $display("FAIL reset_rdata got=%h want=0", {p0_rdata, p1_rdata});
        end
        total++;
        if ({mem_addr, mem_data_in} !== 32'h0) begin
            bad++; $display("FAIL reset_mem_bus got=%h want=0", {mem_addr, mem_data_in});
        end
        do_reset();
    endtask

    task automatic test_load_after_reset();
        do_reset();
        wr_cnt = 0;
        issue(0, 16'd0, 16'h0, 1'b0);
        total++;
        if (wr_cnt !== 0) begin
            bad++; $display("FAIL load_no_write got=%0d want=0", wr_cnt);
        end
    endtask

    task automatic test_store_then_load();
        do_reset();
        wr_cnt = 0;
        issue(1, 16'd2, 16'h1234, 1'b1);
        total++;
        if (wr_cnt !== 1) begin
            bad++; $display("FAIL store_write_cycles got=%0d want=1", wr_cnt);
        end
        total++;
        if (mem[2] !== 16'h1234) begin
            bad++; $display("FAIL store_mem_word got=%h want=1234", mem[2]);
        end
        issue(1, 16'd2, 16'h0, 1'b0);
    endtask

    task automatic test_simultaneous();
        do_reset();
        push_exp(0, 16'd0, 16'h0, 1'b0, cyc + 2);
        push_exp(1, 16'd1, 16'h0, 1'b0, cyc + 4);
        drive(0, 1'b1, 16'd0, 16'h0, 1'b0);
        drive(1, 1'b1, 16'd1, 16'h0, 1'b0);
        wait_ack(0);
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        wait_ack(1);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int n0 = 0, n1 = 0, n = 0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            push_exp(k % 2, (k % 2 == 0) ? 16'd0 : 16'd4, 16'h0, 1'b0, cyc + 2 + 2 * k);
        end
        drive(0, 1'b1, 16'd0, 16'h0, 1'b0);
        drive(1, 1'b1, 16'd4, 16'h0, 1'b0);
        while ((n0 < 3 || n1 < 3) && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (p0_ack) begin
                n0++;
                if (n0 == 3) drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
            end
            if (p1_ack) begin
                n1++;
                if (n1 == 3) drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
            end
        end
        total++;
        if (n0 != 3 || n1 != 3) begin
            bad++; $display("FAIL contention_counts got p0=%0d p1=%0d want 3 3", n0, n1);
        end
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_out_of_range();
        do_reset();
        wr_cnt = 0;
        issue(0, 16'd3, 16'hdead, 1'b1);
        issue(1, 16'hffff, 16'h0, 1'b0);
        total++;
        if (wr_cnt !== 0) begin
            bad++; $display("FAIL oor_no_write got=%0d want=0", wr_cnt);
        end
        total++;
        if ({mem[0], mem[1], mem[2]} !== {shadow[0], shadow[1], shadow[2]}) begin
            bad++; $display("FAIL oor_mem_unchanged got=%h want=%h",
                            {mem[0], mem[1], mem[2]}, {shadow[0], shadow[1], shadow[2]});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 1'b1, 16'd1, 16'h5555, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        init_shadow();
        wr_cnt = 0;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (wr_cnt !== 0) begin
            bad++; $display("FAIL mid_reset_write got=%0d want=0", wr_cnt);
        end
        total++;
        if (mem[1] !== 16'h0) begin
            bad++; $display("FAIL mid_reset_mem got=%h want=0000", mem[1]);
        end
        issue(0, 16'd0, 16'h0, 1'b0);
    endtask

    initial begin
        init_shadow();
        test_reset();
        test_load_after_reset();
        test_store_then_load();
        test_simultaneous();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (sb.size() !== 0) begin
            bad++; $display("FAIL pending_expectations got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
